fir_ctrl_sched: RTL and testbench

AXI-Lite configuration and sequencing controller for the FIR engine. Owns the ap_ctrl and data_length registers and issues the one-cycle start to the engine. Tracks run/done status and arbitrates the single-port tap BRAM between AXI-Lite coefficient access (idle only) and the engine's address generator (run only).

---
 rtl/fir_ctrl_sched_if.sv | 29 ++
 rtl/fir_ctrl_sched.sv | 199 +++++++++++++++++++
 tb/tb_fir_ctrl_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_sched_if.sv
// AXI-Lite bundle (no write-response channel) between the host and fir_ctrl_sched.
// Master drives valids/addresses/data and rready; slave drives the readies and read data.
interface fir_ctrl_sched_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );
endinterface

// File: rtl/fir_ctrl_sched.sv
// FIR control/sequencing: ap_ctrl + data_length regs, one-cycle ap_start, tap BRAM arbitration.
// Latency: write commits the cycle after aw+w capture; read returns rvalid 2 cycles after ar handshake.
// Backpressure: readies drop while a write/read is in flight; rdata held until rready. FIR_CTRL_PERF_CNT_EN adds RUN cycle counter at 0x20.
module fir_ctrl_sched #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    fir_ctrl_sched_if.slave        axi,
    output logic                   ap_start,
    output logic [pDATA_WIDTH-1:0] data_length,
    input  logic                   eng_last,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic                   tap_EN,
    output logic [3:0]             tap_WE,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [pADDR_WIDTH-1:0] A_CTRL   = '0;
    localparam logic [pADDR_WIDTH-1:0] A_LEN    = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] A_TAP_LO = pADDR_WIDTH'(128);
    localparam logic [pADDR_WIDTH-1:0] A_TAP_HI = pADDR_WIDTH'(128 + 4 * Tape_Num - 4);

    logic [0:0]             state_q, state_d;
    logic                   ap_start_q, ap_start_d;
    logic                   done_q, done_d;
    logic [pDATA_WIDTH-1:0] len_q, len_d;
    logic                   init_q;
    logic                   aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
    logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                   ar_ph1_q, ar_ph1_d, ar_ph2_q, ar_ph2_d;
    logic [pADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                   rvalid_q, rvalid_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
    logic [3:0]             tap_we_q, tap_we_d;
    logic [pADDR_WIDTH-1:0] tap_a_q, tap_a_d;
    logic [pDATA_WIDTH-1:0] tap_di_q, tap_di_d;

    logic is_idle, commit, aw_hs, w_hs, ar_hs, rd_hs;

    function automatic logic in_win(input logic [pADDR_WIDTH-1:0] a);
        return (a >= A_TAP_LO) && (a <= A_TAP_HI);
    endfunction

    assign is_idle     = (state_q == S_IDLE);
    assign commit      = aw_cap_q & w_cap_q;
    // Write commit owns the BRAM address register this cycle, so reads wait.
    assign axi.awready = init_q & ~aw_cap_q;
    assign axi.wready  = init_q & ~w_cap_q;
    assign axi.arready = init_q & ~(ar_ph1_q | ar_ph2_q | rvalid_q) & ~commit;
    assign aw_hs       = axi.awvalid & axi.awready;
    assign w_hs        = axi.wvalid & axi.wready;
    assign ar_hs       = axi.arvalid & axi.arready;
    assign rd_hs       = rvalid_q & axi.rready;

`ifdef FIR_CTRL_PERF_CNT_EN
    localparam logic [pADDR_WIDTH-1:0] A_PERF = pADDR_WIDTH'(32);
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (ap_start_d)
            perf_d = '0;
        else if (!is_idle && perf_q != 32'hFFFF_FFFF)
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) perf_q <= '0;
        else             perf_q <= perf_d;
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (araddr_q == A_CTRL)
            rd_mux[2:0] = {is_idle, done_q, ap_start_q};
        else if (araddr_q == A_LEN)
            rd_mux = len_q;
        else if (in_win(araddr_q))
            rd_mux = is_idle ? tap_Do : '1;
`ifdef FIR_CTRL_PERF_CNT_EN
        else if (araddr_q == A_PERF)
            rd_mux = pDATA_WIDTH'(perf_q);
`endif
    end

    always_comb begin
        state_d    = state_q;
        ap_start_d = 1'b0;
        done_d     = done_q;
        len_d      = len_q;
        aw_cap_d   = aw_cap_q | aw_hs;
        w_cap_d    = w_cap_q | w_hs;
        awaddr_d   = aw_hs ? axi.awaddr : awaddr_q;
        wdata_d    = w_hs ? axi.wdata : wdata_q;
        ar_ph1_d   = ar_hs;
        ar_ph2_d   = ar_ph1_q;
        araddr_d   = ar_hs ? axi.araddr : araddr_q;
        rvalid_d   = rvalid_q & ~rd_hs;
        rdata_d    = rdata_q;
        tap_we_d   = 4'h0;
        tap_a_d    = tap_a_q;
        tap_di_d   = tap_di_q;

        if (rd_hs && araddr_q == A_CTRL)
            done_d = 1'b0;

        if (commit) begin
            aw_cap_d = 1'b0;
            w_cap_d  = 1'b0;
            if (is_idle) begin
                if (awaddr_q == A_CTRL) begin
                    if (wdata_q[0] && len_q != '0) begin
                        state_d    = S_RUN;
                        ap_start_d = 1'b1;
                        done_d     = 1'b0;
                    end
                end else if (awaddr_q == A_LEN) begin
                    len_d = wdata_q;
                end else if (in_win(awaddr_q)) begin
                    tap_we_d = 4'hF;
                    tap_a_d  = awaddr_q - A_TAP_LO;
                    tap_di_d = wdata_q;
                end
            end
        end

        if (!is_idle && eng_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end

        if (ar_hs && is_idle && in_win(axi.araddr))
            tap_a_d = axi.araddr - A_TAP_LO;

        if (ar_ph2_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= S_IDLE;
            ap_start_q <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= '0;
            init_q     <= 1'b0;
            aw_cap_q   <= 1'b0;
            w_cap_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            ar_ph1_q   <= 1'b0;
            ar_ph2_q   <= 1'b0;
            araddr_q   <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            tap_we_q   <= 4'h0;
            tap_a_q    <= '0;
            tap_di_q   <= '0;
        end else begin
            state_q    <= state_d;
            ap_start_q <= ap_start_d;
            done_q     <= done_d;
            len_q      <= len_d;
            init_q     <= 1'b1;
            aw_cap_q   <= aw_cap_d;
            w_cap_q    <= w_cap_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            ar_ph1_q   <= ar_ph1_d;
            ar_ph2_q   <= ar_ph2_d;
            araddr_q   <= araddr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            tap_we_q   <= tap_we_d;
            tap_a_q    <= tap_a_d;
            tap_di_q   <= tap_di_d;
        end
    end

    // The engine owns the tap port for the whole run.
    assign tap_EN      = 1'b1;
    assign tap_WE      = is_idle ? tap_we_q : 4'h0;
    assign tap_A       = is_idle ? tap_a_q : eng_tap_A;
    assign tap_Di      = tap_di_q;
    assign ap_start    = ap_start_q;
    assign data_length = len_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
endmodule

// File: tb/tb_fir_ctrl_sched.sv
// Directed bench for fir_ctrl_sched with a behavioural single-port tap BRAM.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_fir_ctrl_sched;
    logic axis_clk   = 1'b0;
    logic axis_rst_n = 1'b0;
    always #5 axis_clk = ~axis_clk;

    fir_ctrl_sched_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) axi ();

    logic        ap_start;
    logic [31:0] data_length;
    logic        eng_last;
    logic [11:0] eng_tap_A;
    logic        tap_EN;
    logic [3:0]  tap_WE;
    logic [11:0] tap_A;
    logic [31:0] tap_Di;
    logic [31:0] tap_Do;

    fir_ctrl_sched #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .axi         (axi),
        .ap_start    (ap_start),
        .data_length (data_length),
        .eng_last    (eng_last),
        .eng_tap_A   (eng_tap_A),
        .tap_EN      (tap_EN),
        .tap_WE      (tap_WE),
        .tap_A       (tap_A),
        .tap_Di      (tap_Di),
        .tap_Do      (tap_Do)
    );

    logic [31:0] mem [0:15];
    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    // Cycles the bench believes the engine has been running.
    logic tb_run = 1'b0;
    int   run_cyc = 0;
    always @(posedge axis_clk) if (tb_run) run_cyc++;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [3:0]  w_we;
    logic [11:0] w_a;
    logic [31:0] w_di;
    logic        w_start;
    int          rd_wait;

    task automatic wr_issue(input logic [11:0] addr, input logic [31:0] data);
        int n = 0;
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        while (!(axi.awready && axi.wready) && n < 50) begin
            @(negedge axis_clk);
            n++;
        end
        chk("wr_accept", 32'(n < 50), 32'h1);
        @(negedge axis_clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
    endtask

    task automatic wr_done();
        @(negedge axis_clk);
        w_we    = tap_WE;
        w_a     = tap_A;
        w_di    = tap_Di;
        w_start = ap_start;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        wr_issue(addr, data);
        wr_done();
    endtask

    task automatic rd_issue(input logic [11:0] addr);
        int n = 0;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        while (!axi.arready && n < 50) begin
            @(negedge axis_clk);
            n++;
        end
        rd_wait = n;
        chk("rd_accept", 32'(n < 50), 32'h1);
        @(negedge axis_clk);
        axi.arvalid = 1'b0;
    endtask

    task automatic rd_finish(input string tag, input logic [31:0] exp, input int stall);
        int lat = 0;
        while (!axi.rvalid && lat < 20) begin
            @(negedge axis_clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        for (int s = 0; s < stall; s++) begin
            @(negedge axis_clk);
            chk({tag, "_hold_vld"}, 32'(axi.rvalid), 32'h1);
            chk({tag, "_hold_dat"}, axi.rdata, exp);
        end
        chk(tag, axi.rdata, exp);
        axi.rready = 1'b1;
        @(negedge axis_clk);
        axi.rready = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        rd_issue(addr);
        rd_finish(tag, exp, 0);
    endtask

    task automatic pulse_last();
        eng_last = 1'b1;
        @(negedge axis_clk);
        eng_last = 1'b0;
        tb_run   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0;
        axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b0;
        eng_last = 1'b0; eng_tap_A = '0;
        repeat (2) @(negedge axis_clk);

        chk("rst_awready", 32'(axi.awready), 32'h0);
        chk("rst_arready", 32'(axi.arready), 32'h0);
        chk("rst_rvalid", 32'(axi.rvalid), 32'h0);
        chk("rst_ap_start", 32'(ap_start), 32'h0);
        chk("rst_len", data_length, 32'h0);
        chk("rst_tap_en", 32'(tap_EN), 32'h1);
        chk("rst_tap_we", 32'(tap_WE), 32'h0);
        chk("rst_tap_a", 32'(tap_A), 32'h0);

        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        chk("post_rst_awready", 32'(axi.awready), 32'h1);
        rd(12'h000, 32'h4, "ctrl_reset");
        chk("ap_start_idle", 32'(ap_start), 32'h0);

        wr(12'h084, 32'hA);
        chk("tapwr_we", 32'(w_we), 32'hF);
        chk("tapwr_a", 32'(w_a), 32'h004);
        chk("tapwr_di", w_di, 32'hA);
        @(negedge axis_clk);
        chk("tapwr_we_one", 32'(tap_WE), 32'h0);
        rd(12'h084, 32'hA, "tap84_rd");

        wr(12'h0A8, 32'h33);
        chk("taplast_we", 32'(w_we), 32'hF);
        chk("taplast_a", 32'(w_a), 32'h028);
        rd(12'h0A8, 32'h33, "taplast_rd");
        wr(12'h0AC, 32'h77);
        chk("tapoob_we", 32'(w_we), 32'h0);
        rd(12'h0AC, 32'h0, "tapoob_rd");
        rd(12'h044, 32'h0, "unmapped_rd");
        rd(12'h020, 32'h0, "perf_rst_rd");

        wr(12'h010, 32'd600);
        rd(12'h010, 32'd600, "len_rd");
        chk("len_port", data_length, 32'd600);

        wr(12'h000, 32'h1);
        tb_run = 1'b1; run_cyc = 0;
        chk("start_pulse", 32'(w_start), 32'h1);
        @(negedge axis_clk);
        chk("start_pulse_end", 32'(ap_start), 32'h0);
        rd(12'h000, 32'h0, "ctrl_run");
        rd(12'h084, 32'hFFFF_FFFF, "tap_run_rd");
        wr(12'h084, 32'h5);
        chk("tap_run_wr_we", 32'(w_we), 32'h0);
        eng_tap_A = 12'h020;
        #1;
        chk("run_tap_a", 32'(tap_A), 32'h020);
        chk("run_tap_we", 32'(tap_WE), 32'h0);
        @(negedge axis_clk);
        wr(12'h010, 32'd7);
        rd(12'h010, 32'd600, "len_run_drop");
        wr(12'h000, 32'h1);
        chk("start_in_run", 32'(w_start), 32'h0);
        rd(12'h000, 32'h0, "ctrl_run2");

        pulse_last();
        rd(12'h000, 32'h6, "ctrl_done");
        rd(12'h000, 32'h4, "ctrl_done_clr");
`ifdef FIR_CTRL_PERF_CNT_EN
        rd(12'h020, 32'(run_cyc), "perf_rd");
`else
        rd(12'h020, 32'h0, "perf_absent_rd");
`endif

        pulse_last();
        rd(12'h000, 32'h4, "last_in_idle");

        wr(12'h000, 32'h1);
        chk("start2_pulse", 32'(w_start), 32'h1);
        pulse_last();
        wr(12'h000, 32'h1);
        chk("start3_pulse", 32'(w_start), 32'h1);
        rd(12'h000, 32'h0, "restart_clr_done");
        pulse_last();
        rd(12'h000, 32'h6, "ctrl_done2");
        rd(12'h084, 32'hA, "tap84_kept");

        wr(12'h010, 32'h0);
        wr(12'h000, 32'h1);
        chk("zero_len_start", 32'(w_start), 32'h0);
        rd(12'h000, 32'h4, "zero_len_ctrl");

        wr_issue(12'h010, 32'h55);
        axi.araddr  = 12'h010;
        axi.arvalid = 1'b1;
        #1;
        chk("commit_blocks_ar", 32'(axi.arready), 32'h0);
        rd_issue(12'h010);
        chk("ar_after_commit", 32'(rd_wait), 32'h1);
        rd_finish("len_stall", 32'h55, 5);
        chk("len_port2", data_length, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
